// File: rtl/irda_pkg.sv
// Shared types and helpers for the IrDA SIR modulator: FSM state encoding and pulse-width selection.
package irda_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CELL = 1'b1
    } state_t;

    localparam int DEF_CLK_PER_BIT = 5208;
    localparam int CNT_W           = $clog2(DEF_CLK_PER_BIT);

    // Mode 0 scales the pulse to 3/16 of a bit cell; mode 1 uses a fixed clock count.
    function automatic int pulse_len(input int mode, input int cpb, input int fixed_clks);
        return (mode == 0) ? (3 * cpb) / 16 : fixed_clks;
    endfunction

endpackage

// File: rtl/irda_sir_modulator_if.sv
// UART-side input line plus LED-side pulse and frame status between the modulator and its neighbours.
interface irda_sir_modulator_if;

    logic tx_en;
    logic uart_tx_data;
    logic tx_pulse_data;
    logic im_sending;
    logic frame_done;

    modport master (
        output tx_en,
        output uart_tx_data,
        input  tx_pulse_data,
        input  im_sending,
        input  frame_done
    );

    modport slave (
        input  tx_en,
        input  uart_tx_data,
        output tx_pulse_data,
        output im_sending,
        output frame_done
    );

endinterface

// File: rtl/irda_cell_timer.sv
// Bit-cell position counter: flags the last clock of a cell and the clocks inside the pulse window.
module irda_cell_timer #(
    parameter int CLK_PER_BIT = 5208,
    parameter int PULSE_START = CLK_PER_BIT / 2,
    parameter int PULSE_LEN   = (3 * CLK_PER_BIT) / 16,
    parameter int CNT_W       = $clog2(CLK_PER_BIT)
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    output logic o_wrap,
    output logic o_in_window
);

    localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(CLK_PER_BIT - 1);
    // One spare bit so the window end may equal CLK_PER_BIT even when that is a power of two.
    localparam logic [CNT_W:0]   LP_WIN_LO = (CNT_W + 1)'(PULSE_START);
    localparam logic [CNT_W:0]   LP_WIN_HI = (CNT_W + 1)'(PULSE_START + PULSE_LEN);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_count_ext;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign w_count_ext = {1'b0, r_count};
    assign o_wrap      = (r_count == LP_LAST);
    assign o_in_window = (w_count_ext >= LP_WIN_LO) && (w_count_ext < LP_WIN_HI);

endmodule

// File: rtl/irda_sir_modulator.sv
// IrDA SIR modulator: turns the UART NRZ line into RZ pulses, one per '0' cell, aligned to the start-bit edge.
module irda_sir_modulator
    import irda_pkg::*;
#(
    parameter int CLK_PER_BIT      = 5208,
    parameter int FRAME_BITS       = 10,
    parameter int PULSE_MODE       = 0,
    parameter int FIXED_PULSE_CLKS = 82,
    parameter int PULSE_START      = CLK_PER_BIT / 2,
    parameter bit OUT_INVERT       = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    irda_sir_modulator_if.slave   bus
);

    localparam int PULSE_LEN = pulse_len(PULSE_MODE, CLK_PER_BIT, FIXED_PULSE_CLKS);
    localparam int TMR_W     = $clog2(CLK_PER_BIT);
    localparam int IDX_W     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [IDX_W-1:0] LP_LAST_BIT = IDX_W'(FRAME_BITS - 1);

    if (PULSE_START + PULSE_LEN > CLK_PER_BIT) begin : g_window_check
        $error("irda_sir_modulator: pulse window extends past the end of the bit cell");
    end
    if (CLK_PER_BIT < 16) begin : g_cpb_check
        $error("irda_sir_modulator: CLK_PER_BIT must be at least 16");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_bit_idx;
    logic [IDX_W-1:0] w_bit_idx_nxt;
    logic             w_clear;
    logic             w_wrap;
    logic             w_in_window;
    logic             w_start;
    logic             w_done_nxt;
    logic             w_pulse;
    logic             r_pulse;
    logic             r_sending;
    logic             r_done;

    irda_cell_timer #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .PULSE_START (PULSE_START),
        .PULSE_LEN   (PULSE_LEN),
        .CNT_W       (TMR_W)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_clear),
        .o_wrap      (w_wrap),
        .o_in_window (w_in_window)
    );

    assign w_start = bus.tx_en && !bus.uart_tx_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    // Timer runs only while inside a cell; every cell boundary, abort or idle cycle rezeroes it.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_idx_nxt = r_bit_idx;
        w_done_nxt    = 1'b0;
        w_clear       = 1'b1;
        case (r_state)
            IDLE: begin
                w_bit_idx_nxt = '0;
                if (w_start) begin
                    w_state_nxt = CELL;
                end
            end
            CELL: begin
                if (!bus.tx_en) begin
                    w_state_nxt   = IDLE;
                    w_bit_idx_nxt = '0;
                end else if (w_wrap) begin
                    if (r_bit_idx != LP_LAST_BIT) begin
                        w_bit_idx_nxt = r_bit_idx + IDX_W'(1);
                    end else begin
                        w_done_nxt    = 1'b1;
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = bus.uart_tx_data ? IDLE : CELL;
                    end
                end else begin
                    w_clear = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_bit_idx_nxt = '0;
            end
        endcase
    end

    // The live line and enable gate the pulse so a rising line or an abort ends it on the next clock.
    assign w_pulse = (r_state == CELL) && bus.tx_en && w_in_window && !bus.uart_tx_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pulse   <= OUT_INVERT;
            r_sending <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_pulse   <= w_pulse ^ OUT_INVERT;
            r_sending <= (r_state == CELL);
            r_done    <= w_done_nxt;
        end
    end

    assign bus.tx_pulse_data = r_pulse;
    assign bus.im_sending    = r_sending;
    assign bus.frame_done    = r_done;

endmodule

// File: tb/tb_irda_sir_modulator.sv
// Bench for irda_sir_modulator: two instances (scaled pulse / fixed inverted pulse) checked cycle by cycle.
module tb_irda_sir_modulator;

    localparam int CPB   = 40;
    localparam int FB    = 10;
    localparam int PS    = 20;
    localparam int FRAME = CPB * FB;

    logic clk;
    logic rst;

    irda_sir_modulator_if bus_a ();
    irda_sir_modulator_if bus_b ();

    irda_sir_modulator #(
        .CLK_PER_BIT      (CPB),
        .FRAME_BITS       (FB),
        .PULSE_MODE       (0),
        .FIXED_PULSE_CLKS (82),
        .PULSE_START      (PS),
        .OUT_INVERT       (1'b0)
    ) u_dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (bus_a)
    );

    irda_sir_modulator #(
        .CLK_PER_BIT      (CPB),
        .FRAME_BITS       (FB),
        .PULSE_MODE       (1),
        .FIXED_PULSE_CLKS (5),
        .PULSE_START      (PS),
        .OUT_INVERT       (1'b1)
    ) u_dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic pulse;
        logic sending;
        logic done;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        int         pulses;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   m_act[2];
    int   m_pos[2];

    logic s_pa, s_pb, s_sa, prev_pa, prev_sa;
    int   rises, hi_cnt, lo_cnt, first_hi, first_lo, done_cnt, done_cyc, sfall;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic clr_stats();
        rises    = 0;
        hi_cnt   = 0;
        lo_cnt   = 0;
        first_hi = -1;
        first_lo = -1;
        done_cnt = 0;
        done_cyc = -1;
        sfall    = 0;
    endtask

    // One clock: drive inputs, predict next-cycle outputs, then compare after the edge.
    task automatic step(input logic en, input logic line);
        exp_t e;
        exp_t ga;
        exp_t gb;
        int   off;
        int   len;
        logic inv;
        bus_a.tx_en        = en;
        bus_a.uart_tx_data = line;
        bus_b.tx_en        = en;
        bus_b.uart_tx_data = line;
        for (int k = 0; k < 2; k++) begin
            len = (k == 0) ? 7 : 5;
            inv = (k == 1);
            off = m_pos[k] % CPB;
            if (rst) begin
                e = '{pulse: inv, sending: 1'b0, done: 1'b0};
            end else begin
                e.pulse   = (m_act[k] && en && !line && off >= PS && off < PS + len) ? ~inv : inv;
                e.sending = m_act[k];
                e.done    = m_act[k] && en && (m_pos[k] == FRAME - 1);
            end
            if (k == 0) qa.push_back(e);
            else        qb.push_back(e);
            if (rst) begin
                m_act[k] = 1'b0;
                m_pos[k] = 0;
            end else if (!m_act[k]) begin
                if (en && !line) begin
                    m_act[k] = 1'b1;
                    m_pos[k] = 0;
                end
            end else if (!en) begin
                m_act[k] = 1'b0;
            end else if (m_pos[k] == FRAME - 1) begin
                if (!line) m_pos[k] = 0;
                else       m_act[k] = 1'b0;
            end else begin
                m_pos[k] = m_pos[k] + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("sb_queue_a", qa.size(), 1);
        chk("sb_queue_b", qb.size(), 1);
        if (qa.size() > 0 && qb.size() > 0) begin
            ga = qa.pop_front();
            gb = qb.pop_front();
            chk("pulse_a",   bus_a.tx_pulse_data, ga.pulse);
            chk("sending_a", bus_a.im_sending,    ga.sending);
            chk("done_a",    bus_a.frame_done,    ga.done);
            chk("pulse_b",   bus_b.tx_pulse_data, gb.pulse);
            chk("sending_b", bus_b.im_sending,    gb.sending);
            chk("done_b",    bus_b.frame_done,    gb.done);
        end
        prev_pa = s_pa;
        prev_sa = s_sa;
        s_pa = bus_a.tx_pulse_data;
        s_pb = bus_b.tx_pulse_data;
        s_sa = bus_a.im_sending;
        if (s_pa && !prev_pa) rises++;
        if (s_pa) begin
            hi_cnt++;
            if (first_hi < 0) first_hi = cyc;
        end
        if (!s_pb) begin
            lo_cnt++;
            if (first_lo < 0) first_lo = cyc;
        end
        if (bus_a.frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!s_sa && prev_sa) sfall++;
    endtask

    // Drives start + 8 data bits LSB first + stop for ncyc clocks; returns the start cycle.
    task automatic send_frame(input logic [7:0] d, input int ncyc, output int t);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        t = cyc;
        for (int i = 0; i < ncyc; i++) begin
            step(1'b1, bits[i / CPB]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1);
    endtask

    vec_t vecs[4];
    int   t0;
    int   t1;

    initial begin
        vecs[0] = '{data: 8'h55, pulses: 5};
        vecs[1] = '{data: 8'h00, pulses: 9};
        vecs[2] = '{data: 8'hF0, pulses: 5};
        vecs[3] = '{data: 8'h81, pulses: 7};

        m_act = '{1'b0, 1'b0};
        m_pos = '{0, 0};
        s_pa = 1'b0; s_pb = 1'b1; s_sa = 1'b0;
        prev_pa = 1'b0; prev_sa = 1'b0;
        clr_stats();
        bus_a.tx_en = 1'b0; bus_a.uart_tx_data = 1'b1;
        bus_b.tx_en = 1'b0; bus_b.uart_tx_data = 1'b1;

        rst = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("reset_pulse_a",   bus_a.tx_pulse_data, 0);
        chk("reset_pulse_b",   bus_b.tx_pulse_data, 1);
        chk("reset_sending_a", bus_a.im_sending, 0);
        chk("reset_done_a",    bus_a.frame_done, 0);
        rst = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 0);
        idle(3);

        // Single '0' cell: pulse position and width for both pulse modes.
        clr_stats();
        send_frame(8'hFF, FRAME, t0);
        idle(4);
        chk("zero_cell_first_hi_a", first_hi - t0, 22);
        chk("zero_cell_width_a",    hi_cnt, 7);
        chk("zero_cell_first_lo_b", first_lo - t0, 22);
        chk("zero_cell_width_b",    lo_cnt, 5);
        chk("zero_cell_rises",      rises, 1);
        chk("zero_cell_done_cnt",   done_cnt, 1);
        chk("zero_cell_done_cyc",   done_cyc - t0, FRAME + 1);

        for (int v = 0; v < 4; v++) begin
            clr_stats();
            send_frame(vecs[v].data, FRAME, t0);
            idle(3);
            chk($sformatf("frame_%02h_pulses", vecs[v].data), rises, vecs[v].pulses);
            chk($sformatf("frame_%02h_done", vecs[v].data), done_cnt, 1);
            chk($sformatf("frame_%02h_sfall", vecs[v].data), sfall, 1);
        end

        // Back-to-back frames: second start bit lands on the final clock of the first frame.
        clr_stats();
        send_frame(8'h55, FRAME, t0);
        send_frame(8'hFF, FRAME, t1);
        idle(4);
        chk("b2b_done_cnt", done_cnt, 2);
        chk("b2b_pulses",   rises, 6);
        chk("b2b_sfall",    sfall, 1);
        chk("b2b_done_cyc", done_cyc - t1, FRAME + 1);

        // Abort mid-pulse in cell 4, then a fresh frame right away.
        clr_stats();
        send_frame(8'h00, 183, t0);
        chk("abort_pre_pulse_a", s_pa, 1);
        step(1'b0, 1'b0);
        chk("abort_idle_a", s_pa, 0);
        chk("abort_idle_b", s_pb, 1);
        step(1'b0, 1'b1);
        chk("abort_sending", s_sa, 0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("abort_no_done", done_cnt, 0);
        clr_stats();
        send_frame(8'h55, FRAME, t0);
        idle(3);
        chk("post_abort_pulses", rises, 5);
        chk("post_abort_done",   done_cnt, 1);

        // Asynchronous reset inside the cell 2 pulse.
        clr_stats();
        send_frame(8'h00, 103, t0);
        chk("prereset_pulse_a", s_pa, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_pulse_a", bus_a.tx_pulse_data, 0);
        chk("async_reset_pulse_b", bus_b.tx_pulse_data, 1);
        chk("async_reset_sending", bus_a.im_sending, 0);
        chk("async_reset_done",    bus_a.frame_done, 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        rst = 1'b0;
        idle(2);
        clr_stats();
        send_frame(8'hFF, FRAME, t0);
        idle(3);
        chk("post_reset_first_hi", first_hi - t0, 22);
        chk("post_reset_width",    hi_cnt, 7);
        chk("post_reset_done_cyc", done_cyc - t0, FRAME + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
